// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch stage, the fetch queue and decode.
// A pair moves on either side only in a cycle where valid and ready are both high at the rising edge.
interface fetch_queue_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] in_instruction;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_instruction;
  logic                  out_misaligned;

  // Fetch/decode side: drives the push request and the pop acknowledge.
  modport master (
    output in_valid, in_pc, in_instruction, out_ready,
    input  in_ready, out_valid, out_pc, out_instruction, out_misaligned
  );

  // Queue side.
  modport slave (
    input  in_valid, in_pc, in_instruction, out_ready,
    output in_ready, out_valid, out_pc, out_instruction, out_misaligned
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: circular buffer of {pc, instruction} pairs with flush.
// Optional zero-latency pass-through when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  fetch_queue_if.slave         bus,
  output logic [CNT_WIDTH-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic full, empty, head_valid, bypass, push, pop;
  logic [DATA_WIDTH-1:0] head_pc, head_instr;

  always_comb begin
    full       = (count_q == CNT_WIDTH'(DEPTH));
    empty      = (count_q == '0);
    head_valid = !empty && !flush;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass     = empty && !flush && bus.in_valid;
`else
    bypass     = 1'b0;
`endif
    bus.in_ready  = !full && !flush;
    bus.out_valid = head_valid || bypass;

    head_pc    = bypass ? bus.in_pc          : pc_mem_q[rd_ptr_q];
    head_instr = bypass ? bus.in_instruction : instr_mem_q[rd_ptr_q];
    // Head fields read as zero whenever nothing valid is presented.
    bus.out_pc          = bus.out_valid ? head_pc    : '0;
    bus.out_instruction = bus.out_valid ? head_instr : '0;
    bus.out_misaligned  = bus.out_valid && (head_pc[1:0] != 2'b00);

    // A bypassed pair taken by decode in the same cycle never enters storage.
    push = bus.in_valid && bus.in_ready && !(bypass && bus.out_ready);
    pop  = head_valid && bus.out_ready;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      pc_mem_q[wr_ptr_q]    <= bus.in_pc;
      instr_mem_q[wr_ptr_q] <= bus.in_instruction;
    end
  end

  assign count = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized plus directed bench for fetch_queue against a queue-based model of the buffer.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic [CW-1:0] count;

  fetch_queue_if #(.DATA_WIDTH(DW)) fq_bus ();

  fetch_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (fq_bus.slave),
    .count (count)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  logic [2*DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: apply inputs just after the falling edge, check outputs against
  // the model, then let the rising edge happen and advance the model.
  task automatic cycle(input bit rst, input bit fl, input bit iv,
                       input logic [DW-1:0] pc, input logic [DW-1:0] ins, input bit ordy);
    int n;
    bit e_rdy, e_val, e_push, e_pop, e_byp;
    logic [DW-1:0] e_pc, e_ins;
    reset = rst; flush = fl;
    fq_bus.in_valid = iv; fq_bus.in_pc = pc; fq_bus.in_instruction = ins;
    fq_bus.out_ready = ordy;
    #1;
    n     = exp_q.size();
    e_rdy = (n != DEPTH) && !fl;
    e_val = (n != 0) && !fl;
    e_byp = 1'b0;
    e_pc  = '0;
    e_ins = '0;
    if (e_val) begin
      e_pc  = exp_q[0][2*DW-1:DW];
      e_ins = exp_q[0][DW-1:0];
    end else if (BYP && n == 0 && !fl && iv) begin
      e_val = 1'b1; e_byp = 1'b1; e_pc = pc; e_ins = ins;
    end
    e_push = iv && e_rdy;
    e_pop  = e_val && ordy;
    if (chk_en) begin
      check("count",      DW'(count),                    DW'(n));
      check("in_ready",   DW'(fq_bus.in_ready),          DW'(e_rdy));
      check("out_valid",  DW'(fq_bus.out_valid),         DW'(e_val));
      check("out_pc",     fq_bus.out_pc,                 e_pc);
      check("out_instr",  fq_bus.out_instruction,        e_ins);
      check("misaligned", DW'(fq_bus.out_misaligned),    DW'(e_val && (e_pc[1:0] != 2'b00)));
    end
    @(posedge clock);
    if (rst || fl) exp_q.delete();
    else if (!(e_byp && e_pop)) begin
      if (e_pop)  void'(exp_q.pop_front());
      if (e_push) exp_q.push_back({pc, ins});
    end
    @(negedge clock);
  endtask

  task automatic push(input logic [DW-1:0] pc, input logic [DW-1:0] ins);
    cycle(0, 0, 1, pc, ins, 0);
  endtask

  task automatic pop_n(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, '0, '0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clock);
    // DUT state is unknown before the first reset edge.
    cycle(1, 0, 1, 32'h44, 32'h1, 0);
    chk_en = 1'b1;
    cycle(1, 0, 1, 32'h48, 32'h2, 0);
    cycle(0, 0, 0, '0, '0, 0);

    // Fill, then a fifth push against a full queue.
    for (int i = 0; i < 4; i++) push(32'(i * 4), 32'h20080001 + 32'(i));
    push(32'h10, 32'h20080005);
    pop_n(4);
    cycle(0, 0, 0, '0, '0, 0);

    // Pointer wrap.
    for (int r = 0; r < 2; r++) begin
      push(32'h200 + 32'(r * 8), 32'hA0 + 32'(r));
      push(32'h204 + 32'(r * 8), 32'hB0 + 32'(r));
      pop_n(2);
    end

    // Simultaneous push and pop at count=2.
    push(32'h300, 32'hC0);
    push(32'h304, 32'hC1);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 32'h308 + 32'(i * 4), 32'hC2 + 32'(i), 1);

    // Flush with a push in the same cycle; then a fresh push.
    push(32'h320, 32'hC8);
    cycle(0, 1, 1, 32'h40, 32'hDEAD, 0);
    cycle(0, 1, 0, '0, '0, 1);
    cycle(0, 0, 0, '0, '0, 0);
    push(32'h80, 32'h1234);
    cycle(0, 0, 0, '0, '0, 0);
    pop_n(1);

    // Misaligned PC at the head.
    push(32'h06, 32'h5555);
    cycle(0, 0, 0, '0, '0, 0);
    pop_n(1);

    // Empty queue with a push taken by decode in the same cycle.
    cycle(0, 0, 1, 32'h100, 32'h7777, 1);
    cycle(0, 0, 0, '0, '0, 0);
    pop_n(1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] rpc;
      rpc = {$urandom_range(0, 32'h3FFF), 2'b00};
      if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 2) != 0, rpc, $urandom, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish by 500000");
    $fatal(1, "timeout");
  end
endmodule
